pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
Central pipeline sequencer for the 5-stage core. Each cycle it decides the write-enable and bubble/flush control for PC, IF/ID, ID/EX, EX/MEM and MEM/WB. Sources are the load-use hazard, taken branches, multi-cycle mul/div, and a data-memory ready handshake. It also tracks a memory-wait timeout and counts stall cycles for performance monitoring.

Parameters:
REGADDR_WIDTH, 4, register-address width
MEM_TIMEOUT, 16, max consecutive MEM_WAIT cycles before abort (>=2)
CNT_WIDTH, 32, stall counter width

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
id_ex_mem_read  in  1  instruction in EX is a load
id_ex_rd  in  REGADDR_WIDTH  EX destination register
if_id_rs  in  REGADDR_WIDTH  ID source 1
if_id_rt  in  REGADDR_WIDTH  ID source 2
branch_taken  in  1  EX resolved a taken branch/jump
muldiv_start  in  1  EX holds a mul/div op (level)
muldiv_done  in  1  mul/div result valid this cycle
mem_req  in  1  MEM stage performing a data access
mem_ready  in  1  data memory completes access this cycle
bus_err_clr  in  1  clear sticky bus_err
pc_write  out  1  PC load enable
if_id_write  out  1  IF/ID enable
if_id_flush  out  1  IF/ID load NOP
id_ex_write  out  1  ID/EX enable
id_ex_bubble  out  1  ID/EX load NOP
ex_mem_write  out  1  EX/MEM enable
ex_mem_bubble  out  1  EX/MEM load NOP
mem_wb_bubble  out  1  MEM/WB load NOP
busy  out  1  state != RUN
bus_err  out  1  sticky memory-timeout flag
stall_cycles  out  CNT_WIDTH  saturating count of cycles with pc_write=0

Behaviour:
- State register: RUN, MEM_WAIT, MD_BUSY. Registered state, wait counter, bus_err and stall_cycles are the only sequential elements. Control outputs are combinational from state and inputs, taking effect in the same cycle.
- Reset, sampled at the clk edge: state=RUN, wait counter=0, bus_err=0, stall_cycles=0. While rst=1, all write enables=0 and all flush/bubble outputs=1.
- Default, with no condition active: all write enables=1 and all bubble/flush outputs=0.
- loaduse = id_ex_mem_read & id_ex_rd!=0 & (id_ex_rd==if_id_rs | id_ex_rd==if_id_rt).
- RUN, conditions in priority order:
  1. mem_req & !mem_ready: freeze everything (all writes=0), mem_wb_bubble=1, go to MEM_WAIT, counter=1.
  2. muldiv_start: pc_write=if_id_write=id_ex_write=0, ex_mem_bubble=1, go to MD_BUSY.
  3. branch_taken: pc_write=1, if_id_flush=1, id_ex_bubble=1. Branch overrides loaduse.
  4. loaduse: pc_write=if_id_write=0, id_ex_bubble=1.
- MEM_WAIT:
  - mem_ready=0 and counter<MEM_TIMEOUT: freeze as in RUN.1 and increment counter.
  - mem_ready=1: apply RUN rules 2-4 (rule 1 ignored) and go to RUN.
  - counter==MEM_TIMEOUT with mem_ready=0: set bus_err, mem_wb_bubble=1 (access discarded), other stages released per RUN rules 2-4, go to RUN.
- MD_BUSY: freeze PC, IF/ID and ID/EX; ex_mem_bubble=1. mem_req is ignored because MEM holds a bubble. On muldiv_done: ex_mem_write=1, no bubble, all stages advance, go to RUN. branch_taken is ignored in MD_BUSY.
- bus_err: set on timeout, cleared by bus_err_clr. If both occur in the same cycle, set wins.
- stall_cycles: increments on every non-reset cycle with pc_write=0 and saturates at all-ones.

Decomposition:
- Shared package pipe_pkg: state encoding constants (RUN=0, MEM_WAIT=1, MD_BUSY=2) and the NOP bubble encoding.
- One sub-module, sat_counter (CNT_WIDTH param, inc, clr), used for stall_cycles.
- Hazard compare stays inline.

Test Plan:
- Reset held 2 cycles, then released with all inputs 0 → during reset all writes 0 and all bubbles 1; after release pc_write=1, bubbles 0, stall_cycles=0.
- id_ex_mem_read=1, id_ex_rd=3, if_id_rs=3 → pc_write=0, if_id_write=0, id_ex_bubble=1 that cycle. Same stimulus with id_ex_rd=0 → no stall.
- loaduse and branch_taken in the same cycle → pc_write=1, if_id_flush=1, id_ex_bubble=1, stall_cycles unchanged.
- mem_req=1 with mem_ready low 3 cycles, then high → 3 frozen cycles with busy=1, release on the 4th cycle, stall_cycles=3.
- mem_req=1, mem_ready=0 held for MEM_TIMEOUT+2 cycles → bus_err=1 after cycle 16, state returns to RUN. bus_err_clr pulse clears bus_err unless coincident with a new timeout.
- muldiv_start at cycle N, muldiv_done at N+5 → ex_mem_bubble=1 for cycles N..N+4, full advance at N+5, busy back to 0 at N+6.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline sequencer: FSM state encoding and the
// instruction word loaded into a pipeline register when it is bubbled.
package pipe_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    MD_BUSY  = 2'd2
  } state_e;

  // addi x0,x0,0 -- the canonical NOP carried by flushed/bubbled stages
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear that holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 inc,
  output logic [CNT_WIDTH-1:0] cnt
);

  logic [CNT_WIDTH-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt_q <= '0;
    end else if (inc && (cnt_q != {CNT_WIDTH{1'b1}})) begin
      cnt_q <= cnt_q + CNT_WIDTH'(1);
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: per-cycle stage enables and bubble/flush controls from
// load-use, branch, mul/div and data-memory handshake; tracks memory timeout.
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int REGADDR_WIDTH = 4,
  parameter int MEM_TIMEOUT   = 16,
  parameter int CNT_WIDTH     = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     id_ex_mem_read,
  input  logic [REGADDR_WIDTH-1:0] id_ex_rd,
  input  logic [REGADDR_WIDTH-1:0] if_id_rs,
  input  logic [REGADDR_WIDTH-1:0] if_id_rt,
  input  logic                     branch_taken,
  input  logic                     muldiv_start,
  input  logic                     muldiv_done,
  input  logic                     mem_req,
  input  logic                     mem_ready,
  input  logic                     bus_err_clr,
  output logic                     pc_write,
  output logic                     if_id_write,
  output logic                     if_id_flush,
  output logic                     id_ex_write,
  output logic                     id_ex_bubble,
  output logic                     ex_mem_write,
  output logic                     ex_mem_bubble,
  output logic                     mem_wb_bubble,
  output logic                     busy,
  output logic                     bus_err,
  output logic [CNT_WIDTH-1:0]     stall_cycles
);

  localparam int                WAIT_W     = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] TIMEOUT_V  = WAIT_W'(MEM_TIMEOUT);

  state_e              state_q, state_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic                bus_err_q;
  logic                loaduse;
  logic                release_run;
  logic                timeout;

  assign loaduse = id_ex_mem_read && (id_ex_rd != '0) &&
                   ((id_ex_rd == if_id_rs) || (id_ex_rd == if_id_rt));

  always_comb begin
    pc_write      = 1'b1;
    if_id_write   = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_write   = 1'b1;
    id_ex_bubble  = 1'b0;
    ex_mem_write  = 1'b1;
    ex_mem_bubble = 1'b0;
    mem_wb_bubble = 1'b0;
    state_d       = state_q;
    wait_d        = wait_q;
    release_run   = 1'b0;
    timeout       = 1'b0;

    unique case (state_q)
      RUN: begin
        if (mem_req && !mem_ready) begin
          {pc_write, if_id_write, id_ex_write, ex_mem_write} = 4'b0000;
          mem_wb_bubble = 1'b1;
          state_d       = MEM_WAIT;
          wait_d        = WAIT_W'(1);
        end else begin
          release_run = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (mem_ready) begin
          release_run = 1'b1;
          state_d     = RUN;
          wait_d      = '0;
        end else if (wait_q < TIMEOUT_V) begin
          {pc_write, if_id_write, id_ex_write, ex_mem_write} = 4'b0000;
          mem_wb_bubble = 1'b1;
          wait_d        = wait_q + WAIT_W'(1);
        end else begin
          // Abandon the access: MEM/WB drops it, upstream stages carry on.
          timeout       = 1'b1;
          mem_wb_bubble = 1'b1;
          release_run   = 1'b1;
          state_d       = RUN;
          wait_d        = '0;
        end
      end
      MD_BUSY: begin
        if (muldiv_done) begin
          state_d = RUN;
        end else begin
          {pc_write, if_id_write, id_ex_write} = 3'b000;
          ex_mem_bubble = 1'b1;
        end
      end
      default: begin
        state_d = RUN;
        wait_d  = '0;
      end
    endcase

    // A mul/div seen on release from a memory wait enters MD_BUSY directly.
    if (release_run) begin
      if (muldiv_start) begin
        {pc_write, if_id_write, id_ex_write} = 3'b000;
        ex_mem_bubble = 1'b1;
        state_d       = MD_BUSY;
      end else if (branch_taken) begin
        if_id_flush  = 1'b1;
        id_ex_bubble = 1'b1;
      end else if (loaduse) begin
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        id_ex_bubble = 1'b1;
      end
    end

    if (rst) begin
      {pc_write, if_id_write, id_ex_write, ex_mem_write} = 4'b0000;
      {if_id_flush, id_ex_bubble, ex_mem_bubble, mem_wb_bubble} = 4'b1111;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RUN;
      wait_q    <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (timeout) begin
        bus_err_q <= 1'b1;
      end else if (bus_err_clr) begin
        bus_err_q <= 1'b0;
      end
    end
  end

  sat_counter #(
    .CNT_WIDTH(CNT_WIDTH)
  ) u_stall_cnt (
    .clk(clk),
    .clr(rst),
    .inc(!pc_write),
    .cnt(stall_cycles)
  );

  assign busy    = (state_q != RUN);
  assign bus_err = bus_err_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed scenarios plus randomized traffic checked against a cycle-level
// behavioural model of the sequencer.
module tb_pipe_ctrl;

  localparam int RW  = 4;
  localparam int TMO = 16;
  localparam int CW  = 32;

  localparam logic [7:0] CTL_DEF  = 8'b1101_0100;
  localparam logic [7:0] CTL_RST  = 8'b0010_1011;
  localparam logic [7:0] CTL_FRZ  = 8'b0000_0001;
  localparam logic [7:0] CTL_MD   = 8'b0000_0110;
  localparam logic [7:0] CTL_BR   = 8'b1111_1100;
  localparam logic [7:0] CTL_LU   = 8'b0001_1100;

  logic          clk = 1'b0;
  logic          rst;
  logic          id_ex_mem_read;
  logic [RW-1:0] id_ex_rd, if_id_rs, if_id_rt;
  logic          branch_taken, muldiv_start, muldiv_done;
  logic          mem_req, mem_ready, bus_err_clr;
  logic          pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble;
  logic          ex_mem_write, ex_mem_bubble, mem_wb_bubble, busy, bus_err;
  logic [CW-1:0] stall_cycles;
  logic [7:0]    ctl;

  int err_cnt = 0;
  int chk_cnt = 0;

  // model state: frozen-for-memory cycle count (0 = not waiting), mul/div busy
  int          m_wait;
  bit          m_md;
  bit          m_berr;
  logic [CW-1:0] m_stall;
  int          n_wait;
  bit          n_md, n_berr;
  logic [CW-1:0] n_stall;
  logic [7:0]  exp_ctl;

  pipe_ctrl #(.REGADDR_WIDTH(RW), .MEM_TIMEOUT(TMO), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .id_ex_mem_read(id_ex_mem_read), .id_ex_rd(id_ex_rd),
    .if_id_rs(if_id_rs), .if_id_rt(if_id_rt),
    .branch_taken(branch_taken), .muldiv_start(muldiv_start),
    .muldiv_done(muldiv_done), .mem_req(mem_req), .mem_ready(mem_ready),
    .bus_err_clr(bus_err_clr),
    .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
    .id_ex_write(id_ex_write), .id_ex_bubble(id_ex_bubble),
    .ex_mem_write(ex_mem_write), .ex_mem_bubble(ex_mem_bubble),
    .mem_wb_bubble(mem_wb_bubble), .busy(busy), .bus_err(bus_err),
    .stall_cycles(stall_cycles)
  );

  assign ctl = {pc_write, if_id_write, if_id_flush, id_ex_write,
                id_ex_bubble, ex_mem_write, ex_mem_bubble, mem_wb_bubble};

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic eval();
    bit frz, rel, tmo, lu;
    frz = 0; rel = 0; tmo = 0;
    exp_ctl = CTL_DEF;
    n_wait  = m_wait;
    n_md    = m_md;
    lu = id_ex_mem_read && (id_ex_rd != 0) &&
         ((id_ex_rd == if_id_rs) || (id_ex_rd == if_id_rt));
    if (m_md) begin
      if (muldiv_done) n_md = 0;
      else exp_ctl = CTL_MD;
    end else if (m_wait > 0) begin
      if (mem_ready) begin rel = 1; n_wait = 0; end
      else if (m_wait < TMO) begin frz = 1; n_wait = m_wait + 1; end
      else begin tmo = 1; rel = 1; n_wait = 0; end
    end else if (mem_req && !mem_ready) begin
      frz = 1; n_wait = 1;
    end else begin
      rel = 1;
    end
    if (frz) exp_ctl = CTL_FRZ;
    if (rel) begin
      if (muldiv_start) begin exp_ctl = CTL_MD; n_md = 1; end
      else if (branch_taken) exp_ctl = CTL_BR;
      else if (lu) exp_ctl = CTL_LU;
    end
    if (tmo) exp_ctl[0] = 1'b1;
    if (rst) begin
      exp_ctl = CTL_RST;
      n_wait = 0; n_md = 0; n_berr = 0; n_stall = '0;
    end else begin
      n_berr  = tmo ? 1'b1 : (bus_err_clr ? 1'b0 : m_berr);
      n_stall = (!exp_ctl[7] && m_stall != '1) ? m_stall + 1 : m_stall;
    end
  endtask

  task automatic model_check(input string tag);
    eval();
    check({tag, ".ctl"}, 64'(ctl), 64'(exp_ctl));
    check({tag, ".busy"}, 64'(busy), 64'(m_md || (m_wait > 0)));
    check({tag, ".berr"}, 64'(bus_err), 64'(m_berr));
    check({tag, ".stall"}, 64'(stall_cycles), 64'(m_stall));
  endtask

  task automatic tick();
    eval();
    @(posedge clk);
    m_wait = n_wait; m_md = n_md; m_berr = n_berr; m_stall = n_stall;
    @(negedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rst = 0; id_ex_mem_read = 0; id_ex_rd = '0; if_id_rs = '0; if_id_rt = '0;
    branch_taken = 0; muldiv_start = 0; muldiv_done = 0;
    mem_req = 0; mem_ready = 0; bus_err_clr = 0;
  endtask

  task automatic do_reset();
    rst = 1; #1;
    model_check("rst");
    tick();
    rst = 0; #1;
  endtask

  initial begin
    logic [CW-1:0] s0;
    m_wait = 0; m_md = 0; m_berr = 0; m_stall = '0;
    idle_inputs();
    rst = 1;
    @(negedge clk); #1;
    check("rst0.ctl", 64'(ctl), 64'(CTL_RST));
    tick();
    check("rst1.ctl", 64'(ctl), 64'(CTL_RST));
    model_check("rst1");
    tick();
    rst = 0; #1;
    check("rel.ctl", 64'(ctl), 64'(CTL_DEF));
    check("rel.stall", 64'(stall_cycles), 64'd0);
    model_check("rel");
    tick();

    // load-use, then same with rd=0
    s0 = stall_cycles;
    id_ex_mem_read = 1; id_ex_rd = 4'd3; if_id_rs = 4'd3; #1;
    check("lu.ctl", 64'(ctl), 64'(CTL_LU));
    model_check("lu");
    tick();
    check("lu.stall", 64'(stall_cycles - s0), 64'd1);
    id_ex_rd = 4'd0; if_id_rs = 4'd0; #1;
    check("lu_r0.ctl", 64'(ctl), 64'(CTL_DEF));
    model_check("lu_r0");
    tick();

    // branch wins over load-use
    s0 = stall_cycles;
    id_ex_rd = 4'd5; if_id_rt = 4'd5; branch_taken = 1; #1;
    check("br_lu.ctl", 64'(ctl), 64'(CTL_BR));
    model_check("br_lu");
    tick();
    check("br_lu.stall", 64'(stall_cycles - s0), 64'd0);
    idle_inputs(); #1;

    // memory wait 3 cycles then ready
    s0 = stall_cycles;
    mem_req = 1;
    for (int i = 0; i < 4; i++) begin
      mem_ready = (i == 3); #1;
      check("mw.ctl", 64'(ctl), 64'((i == 3) ? CTL_DEF : CTL_FRZ));
      check("mw.busy", 64'(busy), 64'(i != 0));
      model_check("mw");
      tick();
    end
    check("mw.stall", 64'(stall_cycles - s0), 64'd3);
    check("mw.busy_end", 64'(busy), 64'd0);
    idle_inputs(); #1;

    // memory timeout
    mem_req = 1;
    for (int i = 0; i < TMO + 2; i++) begin
      #1;
      if (i == TMO) check("tmo.ctl", 64'(ctl), 64'(CTL_DEF | 8'h01));
      if (i == TMO + 1) begin
        check("tmo.berr", 64'(bus_err), 64'd1);
        check("tmo.busy", 64'(busy), 64'd0);
      end
      model_check("tmo");
      tick();
    end
    mem_req = 0; mem_ready = 1; #1;
    model_check("tmo_exit");
    tick();
    mem_ready = 0; bus_err_clr = 1; #1;
    model_check("clr");
    tick();
    check("clr.berr", 64'(bus_err), 64'd0);
    // clear held across a new timeout: set wins
    mem_req = 1;
    for (int i = 0; i < TMO + 1; i++) begin
      #1;
      model_check("tmo2");
      tick();
    end
    check("tmo2.berr", 64'(bus_err), 64'd1);
    idle_inputs(); #1;
    mem_ready = 1; #1;
    model_check("tmo2_exit");
    tick();
    idle_inputs(); #1;

    // mul/div: start at N, done at N+5
    muldiv_start = 1;
    for (int i = 0; i < 6; i++) begin
      muldiv_done = (i == 5); #1;
      check("md.ctl", 64'(ctl), 64'((i == 5) ? CTL_DEF : CTL_MD));
      check("md.busy", 64'(busy), 64'(i != 0));
      model_check("md");
      tick();
    end
    idle_inputs(); #1;
    check("md.busy_end", 64'(busy), 64'd0);
    model_check("md_end");
    tick();

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      rst            = ($urandom_range(0, 199) == 0);
      id_ex_mem_read = ($urandom_range(0, 1) == 1);
      id_ex_rd       = RW'($urandom_range(0, 3));
      if_id_rs       = RW'($urandom_range(0, 3));
      if_id_rt       = RW'($urandom_range(0, 3));
      branch_taken   = ($urandom_range(0, 4) == 0);
      muldiv_start   = ($urandom_range(0, 4) == 0);
      muldiv_done    = ($urandom_range(0, 2) == 0);
      mem_req        = ($urandom_range(0, 2) == 0);
      mem_ready      = ($urandom_range(0, 4) < 2);
      bus_err_clr    = ($urandom_range(0, 9) == 0);
      #1;
      model_check("rnd");
      tick();
    end

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
